// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline sequencer and the pipe
//             registers that decode its hold flag (pc_reg, if_id, id_ex).
//  Contents : hold-flag codes, NOP instruction word, sequencer state type.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Hold flag codes, ordered by how deep into the pipe the freeze reaches.
  localparam logic [1:0] HOLD_NONE = 2'b00;  // nothing held
  localparam logic [1:0] HOLD_PC   = 2'b01;  // pc_reg only
  localparam logic [1:0] HOLD_IF   = 2'b10;  // pc_reg + if_id (load-use slot)
  localparam logic [1:0] HOLD_ID   = 2'b11;  // pc_reg + if_id + id_ex

  // Instruction word injected into if_id/id_ex on a flush.
  localparam logic [31:0] NOP_INST = 32'h0000_0001;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    GRANT = 2'd2
  } ctrl_state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Central pipeline sequencer. Arbitrates between ex multi-cycle
//             holds, clint trap-entry holds and rib bus-master requests;
//             drives the hold flag, redirects the pc on taken jumps followed
//             by a multi-cycle flush, and counts stalled cycles.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             jump_flag_i/addr_i  - taken jump and target from ex
//             hold_ex_i           - ex multi-cycle op busy
//             int_hold_i          - clint trap entry in progress
//             bus_req_i/bus_gnt_o - rib bus-master handshake
//             hold_flag_o         - pipe hold depth (see pipe_ctrl_pkg)
//             jump_flag_o/addr_o  - pc redirect to pc_reg
//             flush_o             - load NOP into if_id/id_ex
//             stall_cnt_o         - cycles with a non-zero hold flag
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              int_hold_i,
  input  logic              bus_req_i,
  output logic              bus_gnt_o,
  output logic [1:0]        hold_flag_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The jump cycle itself is the first flush cycle, so FLUSH only has to
  // cover FLUSH_CYCLES-1 further cycles; the counter runs down to zero.
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LOAD_INT = (FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_LOAD_INT);

  ctrl_state_e       state_q,     state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              bus_gnt_q,   bus_gnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              w_take_jump;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      bus_gnt_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      bus_gnt_q   <= bus_gnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    bus_gnt_d   = bus_gnt_q;
    w_take_jump = 1'b0;
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    flush_o     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (jump_flag_i) begin
          w_take_jump = 1'b1;
        end else if (int_hold_i || hold_ex_i) begin
          hold_flag_o = HOLD_ID;
        end else if (bus_req_i) begin
          // Only the pc is frozen while the grant is being set up; the
          // instructions already in flight drain this cycle.
          hold_flag_o = HOLD_PC;
          state_d     = GRANT;
          bus_gnt_d   = 1'b1;
        end
      end

      FLUSH: begin
        flush_o = 1'b1;
        if (jump_flag_i) begin
          w_take_jump = 1'b1;
        end else begin
          // Bus requests wait for RUN so the grant never overlaps a flush.
          if (int_hold_i || hold_ex_i) begin
            hold_flag_o = HOLD_ID;
          end
          if (flush_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end

      GRANT: begin
        // A jump seen here is dropped: ex is frozen, so it re-presents the
        // same jump once the pipe is released.
        hold_flag_o = HOLD_ID;
        if (!bus_req_i) begin
          state_d   = RUN;
          bus_gnt_d = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Jump overrides any concurrent hold (jump with hold_ex is illegal from
    // ex; resolving it as a jump keeps the pc moving).
    if (w_take_jump) begin
      hold_flag_o = HOLD_NONE;
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
      flush_o     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d = RUN;
      end
    end

    // Reset silences every decoded output in the same cycle.
    if (rst) begin
      hold_flag_o = HOLD_NONE;
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
      flush_o     = 1'b0;
    end

    stall_cnt_d = stall_cnt_q + CNT_W'(hold_flag_o != HOLD_NONE);
  end

  assign bus_gnt_o   = bus_gnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule : pipe_ctrl
`default_nettype wire
